// File: rtl/manhattan_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : manhattan_scheduler
// Brief   : Time-multiplexes one shared Manhattan weight-update unit across
//           NUM_WEIGHTS weights. Operands are snapshotted on start, weights
//           are issued one at a time, and results are gathered into a bus
//           that is presented together with the next-sweep eta on done.
// Config  : ETA_DECAY_EN - when defined, eta_out takes the last eta returned
//           by the unit (snapshot eta if no weight was issued). When
//           undefined, eta_out is the snapshot eta and mu_new_eta is unused.
// Revision: 1.0 - initial release
// ============================================================================
module manhattan_scheduler #(
  parameter int BIT_WIDTH    = 32,
  parameter int EXTRA_BITS   = 2,
  parameter int NUM_WEIGHTS  = 4,
  parameter int UNIT_LATENCY = 2
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic [NUM_WEIGHTS*(BIT_WIDTH+EXTRA_BITS)-1:0]   Old_Weights_Bus,
  input  logic [NUM_WEIGHTS*(BIT_WIDTH+EXTRA_BITS)-1:0]   Error_Bus,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0]                 eta_in,
  output logic                                             busy,
  output logic                                             done,
  output logic [NUM_WEIGHTS*(BIT_WIDTH+EXTRA_BITS)-1:0]   Updated_Weights_Bus,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0]                 eta_out,
  output logic                                             Manhattan_Enable,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0]                 mu_old_weight,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0]                 mu_error,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0]                 mu_eta,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0]                 mu_updated_weight,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0]                 mu_new_eta
);

  localparam int W    = BIT_WIDTH + EXTRA_BITS;
  localparam int IDXW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
  localparam int CNTW = (UNIT_LATENCY > 1) ? $clog2(UNIT_LATENCY) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NUM_WEIGHTS - 1);
  localparam logic [CNTW-1:0] C_LAST_CNT = CNTW'(UNIT_LATENCY - 1);

  logic [1:0]      r_state, w_next_state;
  logic [IDXW-1:0] r_idx;
  logic [CNTW-1:0] r_cnt;
  logic [W-1:0]    r_weights [NUM_WEIGHTS];
  logic [W-1:0]    r_errors  [NUM_WEIGHTS];
  logic [W-1:0]    r_slots   [NUM_WEIGHTS];
  logic [W-1:0]    w_slots_next [NUM_WEIGHTS];
  logic [W-1:0]    r_eta;
  logic [W-1:0]    w_eta_final;
  logic            w_skip, w_last, w_slot_we;
  logic [W-1:0]    w_slot_wd;

  // A zero-tagged error means the update would be a no-op, so the unit is bypassed
  assign w_skip = (r_errors[r_idx][W-1 -: 2] == 2'b00);
  assign w_last = (r_idx == C_LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_ISSUE;
      S_ISSUE: begin
        if (w_skip)                 w_next_state = w_last ? S_DONE : S_ISSUE;
        else if (r_cnt == C_LAST_CNT) w_next_state = S_CAPTURE;
      end
      S_CAPTURE: w_next_state = w_last ? S_DONE : S_ISSUE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Output decode; mu_* follow the snapshot at idx so they hold when idle
  always_comb begin
    busy             = (r_state != S_IDLE);
    done             = (r_state == S_DONE);
    Manhattan_Enable = (r_state == S_ISSUE) && !w_skip;
    mu_old_weight    = r_weights[r_idx];
    mu_error         = r_errors[r_idx];
    mu_eta           = r_eta;
  end

  // Result-slot write: pass-through on skip, unit result on capture
  always_comb begin
    w_slot_we = 1'b0;
    w_slot_wd = r_weights[r_idx];
    if (r_state == S_ISSUE && w_skip) begin
      w_slot_we = 1'b1;
    end else if (r_state == S_CAPTURE) begin
      w_slot_we = 1'b1;
      w_slot_wd = mu_updated_weight;
    end
    for (int i = 0; i < NUM_WEIGHTS; i++) w_slots_next[i] = r_slots[i];
    if (w_slot_we) w_slots_next[r_idx] = w_slot_wd;
  end

`ifdef ETA_DECAY_EN
  logic [W-1:0] r_eta_cand;

  // Candidate eta starts at the snapshot so an all-skip sweep keeps it
  always_ff @(posedge clk) begin
    if (!rst)                                 r_eta_cand <= '0;
    else if (r_state == S_IDLE && start)      r_eta_cand <= eta_in;
    else if (r_state == S_CAPTURE)            r_eta_cand <= mu_new_eta;
  end

  assign w_eta_final = (r_state == S_CAPTURE) ? mu_new_eta : r_eta_cand;
`else
  logic w_unused_new_eta;
  assign w_unused_new_eta = ^mu_new_eta;
  assign w_eta_final      = r_eta;
`endif

  // Datapath: snapshot, sequencing counters, slots and published outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_eta   <= '0;
      eta_out <= '0;
      Updated_Weights_Bus <= '0;
      for (int i = 0; i < NUM_WEIGHTS; i++) begin
        r_weights[i] <= '0;
        r_errors[i]  <= '0;
        r_slots[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WEIGHTS; i++) r_slots[i] <= w_slots_next[i];
      case (r_state)
        S_IDLE: if (start) begin
          r_idx <= '0;
          r_cnt <= '0;
          r_eta <= eta_in;
          for (int i = 0; i < NUM_WEIGHTS; i++) begin
            r_weights[i] <= Old_Weights_Bus[i*W +: W];
            r_errors[i]  <= Error_Bus[i*W +: W];
          end
        end
        S_ISSUE: begin
          if (w_skip) begin
            r_cnt <= '0;
            if (!w_last) r_idx <= r_idx + IDXW'(1);
          end else begin
            r_cnt <= (r_cnt == C_LAST_CNT) ? '0 : r_cnt + CNTW'(1);
          end
        end
        S_CAPTURE: if (!w_last) r_idx <= r_idx + IDXW'(1);
        default: ;
      endcase
      // Publish on entry to DONE so the buses are valid during the done pulse
      if (w_next_state == S_DONE) begin
        eta_out <= w_eta_final;
        for (int i = 0; i < NUM_WEIGHTS; i++)
          Updated_Weights_Bus[i*W +: W] <= w_slots_next[i];
      end
    end
  end

endmodule
`default_nettype wire
